// File: rtl/systolic_skew_feeder.sv
// Skews LENGTH-lane operand vectors into a diagonal wavefront for a systolic array.
// Optional SKEW_AUTO_CLEAR_EN adds Mmu_Clr, pulsed on the first accept of each operand set.
module systolic_skew_feeder #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned LENGTH = 3,
    parameter int unsigned DRAIN  = 2 * LENGTH - 1
) (
    input  logic                    CLK,
    input  logic                    ASYNC_RST,
    input  logic                    SYNC_RST,
    input  logic                    In_Valid,
    output logic                    In_Ready,
    input  logic [LENGTH*WIDTH-1:0] In_A,
    input  logic [LENGTH*WIDTH-1:0] In_B,
    output logic [LENGTH*WIDTH-1:0] Out_A,
    output logic [LENGTH*WIDTH-1:0] Out_B,
    output logic                    Mmu_En,
    output logic                    Busy,
    output logic                    Done
`ifdef SKEW_AUTO_CLEAR_EN
    ,
    output logic                    Mmu_Clr
`endif
);

    localparam int unsigned MaxCnt = (LENGTH > DRAIN) ? LENGTH : DRAIN;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StLoad  = 2'd1;
    localparam logic [1:0] StFlush = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
    logic [CntW-1:0] drain_cnt_q, drain_cnt_d;
    logic            mmu_en_q;
    logic            accept;
    logic            shift;

    always_comb begin
        In_Ready = (state_q == StIdle) || (state_q == StLoad);
        accept   = In_Valid && In_Ready;
        // Zeros are shifted in during FLUSH; a pending sync reset suppresses any shift.
        shift    = !SYNC_RST && (accept || (state_q == StFlush));
    end

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        drain_cnt_d = drain_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    beat_cnt_d  = CntW'(1);
                    drain_cnt_d = '0;
                    state_d     = (LENGTH == 32'd1) ? StFlush : StLoad;
                end
            end
            StLoad: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == CntW'(LENGTH - 1)) begin
                        state_d     = StFlush;
                        drain_cnt_d = '0;
                    end
                end
            end
            StFlush: begin
                drain_cnt_d = drain_cnt_q + 1'b1;
                if (drain_cnt_q == CntW'(DRAIN - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d     = StIdle;
                beat_cnt_d  = '0;
                drain_cnt_d = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            state_q     <= StIdle;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            mmu_en_q    <= 1'b0;
        end else if (SYNC_RST) begin
            state_q     <= StIdle;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            mmu_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            mmu_en_q    <= shift;
        end
    end

    // Lane i is a chain of i+1 registers, so its element leaves i+1 shifts after acceptance.
    for (genvar i = 0; i < LENGTH; i++) begin : g_lane
        logic [WIDTH-1:0] a_q [i+1];
        logic [WIDTH-1:0] b_q [i+1];
        logic [WIDTH-1:0] head_a;
        logic [WIDTH-1:0] head_b;

        assign head_a = accept ? In_A[i*WIDTH +: WIDTH] : '0;
        assign head_b = accept ? In_B[i*WIDTH +: WIDTH] : '0;

        always_ff @(posedge CLK or negedge ASYNC_RST) begin
            if (!ASYNC_RST) begin
                for (int s = 0; s <= i; s++) begin
                    a_q[s] <= '0;
                    b_q[s] <= '0;
                end
            end else if (SYNC_RST) begin
                for (int s = 0; s <= i; s++) begin
                    a_q[s] <= '0;
                    b_q[s] <= '0;
                end
            end else if (shift) begin
                a_q[0] <= head_a;
                b_q[0] <= head_b;
                for (int s = 1; s <= i; s++) begin
                    a_q[s] <= a_q[s-1];
                    b_q[s] <= b_q[s-1];
                end
            end
        end

        assign Out_A[i*WIDTH +: WIDTH] = a_q[i];
        assign Out_B[i*WIDTH +: WIDTH] = b_q[i];
    end

    assign Mmu_En = mmu_en_q;
    assign Busy   = (state_q != StIdle);
    assign Done   = (state_q == StDone);

`ifdef SKEW_AUTO_CLEAR_EN
    assign Mmu_Clr = (state_q == StIdle) && In_Valid && !SYNC_RST;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder: directed vectors plus a queue-based lane model.
module tb_systolic_skew_feeder;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned LENGTH = 3;
    localparam int unsigned DRAIN  = 2 * LENGTH - 1;
    localparam int unsigned VW     = LENGTH * WIDTH;

    logic          CLK;
    logic          ASYNC_RST;
    logic          SYNC_RST;
    logic          In_Valid;
    logic          In_Ready;
    logic [VW-1:0] In_A;
    logic [VW-1:0] In_B;
    logic [VW-1:0] Out_A;
    logic [VW-1:0] Out_B;
    logic          Mmu_En;
    logic          Busy;
    logic          Done;
`ifdef SKEW_AUTO_CLEAR_EN
    logic          Mmu_Clr;
`endif

    systolic_skew_feeder #(
        .WIDTH (WIDTH),
        .LENGTH(LENGTH),
        .DRAIN (DRAIN)
    ) dut (
        .CLK      (CLK),
        .ASYNC_RST(ASYNC_RST),
        .SYNC_RST (SYNC_RST),
        .In_Valid (In_Valid),
        .In_Ready (In_Ready),
        .In_A     (In_A),
        .In_B     (In_B),
        .Out_A    (Out_A),
        .Out_B    (Out_B),
        .Mmu_En   (Mmu_En),
        .Busy     (Busy),
        .Done     (Done)
`ifdef SKEW_AUTO_CLEAR_EN
        ,
        .Mmu_Clr  (Mmu_Clr)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Reference model: beats accepted in the current set, flush cycles done, and the
    // history of vectors pushed into the lane heads (newest at the back).
    int            m_beats = 0;
    int            m_fl    = 0;
    logic          m_en    = 1'b0;
    logic [VW-1:0] hist_a[$];
    logic [VW-1:0] hist_b[$];

    logic s_ready;
    logic s_done;
    logic s_acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_beats = 0;
        m_fl    = 0;
        m_en    = 1'b0;
        hist_a.delete();
        hist_b.delete();
    endtask

    task automatic model_push(input logic [VW-1:0] a, input logic [VW-1:0] b);
        hist_a.push_back(a);
        hist_b.push_back(b);
        if (hist_a.size() > LENGTH) begin
            void'(hist_a.pop_front());
            void'(hist_b.pop_front());
        end
    endtask

    // Lane i shows the value pushed i shifts before the newest push.
    function automatic logic [VW-1:0] exp_out(input bit use_b);
        logic [VW-1:0] r;
        logic [VW-1:0] v;
        int            idx;
        r = '0;
        for (int i = 0; i < LENGTH; i++) begin
            idx = hist_a.size() - 1 - i;
            if (idx >= 0) begin
                v = use_b ? hist_b[idx] : hist_a[idx];
                r[i*WIDTH +: WIDTH] = v[i*WIDTH +: WIDTH];
            end
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] r;
        for (int i = 0; i < LENGTH; i++) r[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        return r;
    endfunction

    // One clock: check combinational outputs before the edge, advance model, check after.
    task automatic cycle();
        logic          acc;
        logic          fl;
        logic          dn;
        logic          rst;
        logic [VW-1:0] a;
        logic [VW-1:0] b;
        #1;
        acc = In_Valid && (m_beats < LENGTH);
        fl  = (m_beats == LENGTH) && (m_fl < DRAIN);
        dn  = (m_beats == LENGTH) && (m_fl == DRAIN);
        rst = SYNC_RST;
        a   = In_A;
        b   = In_B;
        s_ready = In_Ready;
        s_done  = Done;
        s_acc   = acc && !rst;
        check("in_ready", In_Ready, m_beats < LENGTH);
        check("done", Done, dn);
        check("busy", Busy, m_beats != 0);
`ifdef SKEW_AUTO_CLEAR_EN
        check("mmu_clr", Mmu_Clr, !rst && In_Valid && (m_beats == 0));
`endif
        @(posedge CLK);
        #1;
        if (rst) begin
            model_reset();
        end else if (acc) begin
            m_beats++;
            model_push(a, b);
            m_en = 1'b1;
        end else if (fl) begin
            m_fl++;
            model_push('0, '0);
            m_en = 1'b1;
        end else begin
            if (dn) begin
                m_beats = 0;
                m_fl    = 0;
            end
            m_en = 1'b0;
        end
        check("out_a", Out_A, exp_out(1'b0));
        check("out_b", Out_B, exp_out(1'b1));
        check("mmu_en", Mmu_En, m_en);
    endtask

    task automatic drain_idle();
        int n = 0;
        In_Valid = 1'b0;
        while (m_beats != 0 && n < 60) begin
            cycle();
            n++;
        end
        check("drain_timeout", m_beats, 0);
    endtask

    logic [VW-1:0] a_beats [3];
    logic [VW-1:0] b_beats [3];
    logic [VW-1:0] tab_a [10];
    logic [VW-1:0] tab_b [10];

    initial begin
        int done_j;
        int acc_j;
        int n_acc;
        int ndone;

        a_beats = '{24'h070401, 24'h080502, 24'h090603};
        b_beats = '{24'h010201, 24'h060402, 24'h050207};
        tab_a   = '{24'h000001, 24'h000402, 24'h070503, 24'h080600, 24'h090000,
                    24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
        tab_b   = '{24'h000001, 24'h000202, 24'h010407, 24'h060200, 24'h050000,
                    24'h0, 24'h0, 24'h0, 24'h0, 24'h0};

        ASYNC_RST = 1'b1;
        SYNC_RST  = 1'b0;
        In_Valid  = 1'b0;
        In_A      = '0;
        In_B      = '0;
        #1 ASYNC_RST = 1'b0;
        #2;
        check("rst_out_a", Out_A, 0);
        check("rst_out_b", Out_B, 0);
        check("rst_mmu_en", Mmu_En, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        #9 ASYNC_RST = 1'b1;
        #1;
        check("rel_in_ready", In_Ready, 1);
        check("rel_mmu_en", Mmu_En, 0);
        model_reset();
        @(posedge CLK);
        #1;

        // Back-to-back load of the reference operand set.
        for (int j = 0; j < 10; j++) begin
            In_Valid = (j < 3);
            In_A     = (j < 3) ? a_beats[j] : '0;
            In_B     = (j < 3) ? b_beats[j] : '0;
            cycle();
            check("b2b_out_a", Out_A, tab_a[j]);
            check("b2b_out_b", Out_B, tab_b[j]);
            check("b2b_mmu_en", Mmu_En, j <= 7);
            check("b2b_done", s_done, j == 8);
        end
        drain_idle();

        // Stall for two cycles between beat 1 and beat 2.
        done_j = -1;
        for (int j = 0; j < 30; j++) begin
            In_Valid = (j == 0) || (j == 3) || (j == 4);
            In_A     = (j == 0) ? a_beats[0] : (j == 3) ? a_beats[1] : a_beats[2];
            In_B     = (j == 0) ? b_beats[0] : (j == 3) ? b_beats[1] : b_beats[2];
            cycle();
            if (j == 1 || j == 2) check("stall_freeze_a", Out_A, 24'h000001);
            if (j == 1 || j == 2) check("stall_freeze_en", Mmu_En, 0);
            if (s_done) begin
                done_j = j;
                break;
            end
        end
        check("stall_done_cycle", done_j, LENGTH + DRAIN + 2);
        drain_idle();

        // In_Valid held high across two sets.
        done_j = -1;
        acc_j  = -1;
        n_acc  = 0;
        In_Valid = 1'b1;
        for (int j = 0; j < 2 * (LENGTH + DRAIN + 1); j++) begin
            In_A = rand_vec();
            In_B = rand_vec();
            cycle();
            if (s_acc) n_acc++;
            if (s_acc && done_j >= 0 && acc_j < 0) acc_j = j;
            if (s_done && done_j < 0) done_j = j;
        end
        check("bp_accept_count", n_acc, 2 * LENGTH);
        check("bp_next_accept", acc_j, done_j + 1);
        drain_idle();

        // Sync reset in the second FLUSH cycle aborts without Done.
        In_Valid = 1'b1;
        for (int j = 0; j < LENGTH; j++) begin
            In_A = rand_vec();
            In_B = rand_vec();
            cycle();
        end
        In_Valid = 1'b0;
        cycle();
        SYNC_RST = 1'b1;
        cycle();
        SYNC_RST = 1'b0;
        check("srst_out_a", Out_A, 0);
        check("srst_busy", Busy, 0);
        ndone = 0;
        for (int j = 0; j < LENGTH + DRAIN + 2; j++) begin
            cycle();
            if (s_done) ndone++;
        end
        check("srst_no_done", ndone, 0);

        // Sync reset together with an accept drops the beat.
        In_Valid = 1'b1;
        In_A     = rand_vec();
        In_B     = rand_vec();
        SYNC_RST = 1'b1;
        cycle();
        SYNC_RST = 1'b0;
        In_Valid = 1'b0;
        check("srst_acc_busy", Busy, 0);
        check("srst_acc_out", Out_A, 0);
        cycle();

        // Async reset mid-LOAD.
        In_Valid = 1'b1;
        for (int j = 0; j < 2; j++) begin
            In_A = rand_vec();
            In_B = rand_vec();
            cycle();
        end
        In_Valid  = 1'b0;
        ASYNC_RST = 1'b0;
        #1;
        check("arst_out_a", Out_A, 0);
        check("arst_out_b", Out_B, 0);
        check("arst_mmu_en", Mmu_En, 0);
        check("arst_busy", Busy, 0);
        model_reset();
        #2 ASYNC_RST = 1'b1;
        for (int j = 0; j < 4; j++) cycle();

        // Random traffic with rare sync resets.
        for (int j = 0; j < 400; j++) begin
            In_Valid = ($urandom_range(0, 9) < 7);
            In_A     = rand_vec();
            In_B     = rand_vec();
            SYNC_RST = ($urandom_range(0, 59) == 0);
            cycle();
        end
        SYNC_RST = 1'b0;
        drain_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Upstream feeder for the Matrix_Multiply_Unit systolic array.
- Accepts one un-skewed LENGTH-lane vector per beat for each operand stream (A = Inputs, B = Weights) through a valid/ready handshake.
- Delays lane i by i shifts, producing the diagonal wavefront the array expects, then flushes zeros so the array drains.
- Drives the array's EN, and pulses Done when a full LENGTH-beat operand set has propagated.

Parameters:
- WIDTH, 8: bits per operand element.
- LENGTH, 3: array dimension; number of lanes and number of beats per operand set (LENGTH ≥ 1).
- DRAIN, 2*LENGTH-1: zero-flush cycles after the last accepted beat.

Ports:
- CLK  in  1  clock, rising edge.
- ASYNC_RST  in  1  asynchronous reset, active-low.
- SYNC_RST  in  1  synchronous reset, active-high; same effect as ASYNC_RST, applied at the clock edge.
- In_Valid  in  1  an operand beat is present.
- In_Ready  out  1  feeder can accept a beat.
- In_A  in  LENGTH*WIDTH  A vector; lane i = bits [i*WIDTH +: WIDTH].
- In_B  in  LENGTH*WIDTH  B vector; same lane packing.
- Out_A  out  LENGTH*WIDTH  skewed A lanes to array Inputs.
- Out_B  out  LENGTH*WIDTH  skewed B lanes to array Weights.
- Mmu_En  out  1  array enable (shift/accumulate this cycle).
- Busy  out  1  state is not IDLE.
- Done  out  1  one-cycle pulse: operand set fully drained.

Behaviour:
- Reset (async or sync): state IDLE, beat/drain counters 0, all delay registers 0, Out_A = Out_B = 0, Mmu_En = 0, Done = 0, Busy = 0.
- Lane structure:
  - Lane i of each operand is a chain of i+1 registers.
  - Every register updates only on a "shift" cycle; otherwise it holds.
  - Out lane i = last register of the chain, so an accepted element appears on Out i+1 shifts after acceptance.
- Shift cycle definition:
  - Accept cycle: In_Valid & In_Ready. The head register of each lane loads In_A/In_B.
  - Any cycle in FLUSH: head registers load 0.
- Mmu_En is registered. It is 1 in the cycle after every shift cycle, aligned with the new Out values; otherwise 0. The array therefore freezes whenever the feeder stalls.
- State machine:
  - IDLE:
    - In_Ready = 1.
    - On accept: beat_cnt = 1; go to LOAD, or go to FLUSH if LENGTH == 1.
  - LOAD:
    - In_Ready = 1.
    - On accept: beat_cnt++; when beat_cnt reaches LENGTH, go to FLUSH with drain_cnt = 0.
    - In_Valid low: stall; no shift, and no zero bubble is inserted.
  - FLUSH:
    - In_Ready = 0.
    - Shift zeros every cycle, drain_cnt++.
    - When drain_cnt == DRAIN-1, go to DONE.
  - DONE:
    - In_Ready = 0; Done = 1 for exactly this cycle.
    - Delay registers hold (all zero); go to IDLE.
- Timing: the last accepted beat's lane LENGTH-1 element leaves Out LENGTH shifts after acceptance. DRAIN then covers array propagation. Done is asserted exactly LENGTH + DRAIN cycles after the first accept, when there are no stalls.
- Boundary cases:
  - In_Valid held high from IDLE: LENGTH back-to-back beats are accepted.
  - The next set is accepted only after returning to IDLE; In_Valid asserted during FLUSH/DONE waits.
  - Reset mid-LOAD or mid-FLUSH: abort immediately to reset values, with no Done pulse.
  - SYNC_RST and an accept in the same cycle: reset wins and the beat is dropped.
- Arithmetic: no arithmetic; widths are pass-through. Counters are sized $clog2(max(LENGTH, DRAIN)+1).

Optional Feature:
- Macro: SKEW_AUTO_CLEAR_EN.
- When defined:
  - Adds output port Mmu_Clr (1 bit, to the array's SYNC_RST), reset value 0.
  - Mmu_Clr is combinationally 1 in the IDLE accept cycle, so array accumulators clear on the same edge the first beat is captured.
  - The first non-zero Out value reaches a freshly cleared array.
- When undefined: no Mmu_Clr port; the integrator clears the array externally between operand sets.

Test Plan:
- Reset values: ASYNC_RST low mid-cycle → all outputs 0 immediately, Busy 0; release → In_Ready 1, Mmu_En 0.
- LENGTH=3 back-to-back load:
  - Stimulus: A beats {1,4,7}, {2,5,8}, {3,6,9} (lane0, lane1, lane2) and B beats {1,2,1}, {2,4,6}, {7,2,5}.
  - Out_A per cycle after the first accept: {1,0,0}, {2,4,0}, {3,5,7}, {0,6,8}, {0,0,9}, then zeros. Out_B has the matching pattern.
  - Mmu_En is high for 8 cycles; Done is asserted exactly 8 cycles after the first accept.
- Stall: drop In_Valid for 2 cycles between beat 1 and beat 2 → Out values and Mmu_En freeze for 2 cycles; sequence otherwise identical; Done slips by exactly 2 cycles.
- Backpressure: In_Valid held high through FLUSH → In_Ready 0 during FLUSH and DONE; the next set's first beat is accepted the cycle after Done; no beat is lost or duplicated.
- Reset mid-operation: SYNC_RST pulsed in the 2nd FLUSH cycle → outputs 0 next edge, state IDLE, no Done pulse.
- SKEW_AUTO_CLEAR_EN: Mmu_Clr is high only in the first-accept cycle of each set, and 0 during LOAD, FLUSH and DONE.
